aes_spi_sequencer: RTL
======================

AES_SPI_SEQUENCER -- requirements
Module: aes_spi_sequencer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50: clk cycles per half bit period of sclk; legal range 2..255.
REQ-002 SHALL have parameter WAIT_BITS, default 16: idle bit periods between the last key bit and the first result bit.
REQ-003 clk  in  1  single clock for all logic; every flop on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request one transaction; sampled only in IDLE.
REQ-006 size  in  2  key size: 00=128, 01=192, 10=256, 11=illegal.
REQ-007 msg  in  128  plaintext; captured at start.
REQ-008 key  in  256  key, left-justified (active field ends at bit 255); captured at start.
REQ-009 expected  in  128  reference for the result compare; captured at start.
REQ-010 miso  in  1  serial result from the AES slave.
REQ-011 cs_n, sclk, mosi  out  1 each  SPI chip select (active low), serial clock, serial data.
REQ-012 mode  out  1  slave phase select: 0=load, 1=readback.
REQ-013 busy, done, match, err  out  1 each  status; done is a 1-cycle pulse.
REQ-014 result  out  128  received ciphertext.

Function
REQ-015 SHALL implement states IDLE, LOAD, SEND_MSG, SEND_KEY, WAIT, RECV, DONE.
REQ-016 IDLE: start=1 and size!=11 -> LOAD and capture msg/key/expected/size; start=1 and size=11 -> err=1 for exactly one cycle, stay IDLE.
REQ-017 LOAD: one clk cycle; drive cs_n=0; bit counter cleared; -> SEND_MSG.
REQ-018 Bit period = 2*CLK_DIV clk cycles: sclk low first half, high second half; sclk=0 whenever cs_n=1.
REQ-019 mosi SHALL change only at bit-period start; miso SHALL be sampled on the clk cycle sclk rises.
REQ-020 SEND_MSG: 128 bits, msg[0] first to msg[127].
REQ-021 SEND_KEY: 128/192/256 bits starting at key[128]/key[64]/key[0], ascending to key[255].
REQ-022 WAIT: WAIT_BITS bit periods; mosi=0; sclk runs; mode switches to 1 on entry.
REQ-023 RECV: 128 bits shifted into result MSB-side, right shift (first received bit ends in result[0]).
REQ-024 DONE: cs_n=1, mode=0, done=1 for one cycle, busy=0 next cycle, -> IDLE.
REQ-025 busy=1 in every state except IDLE.
REQ-026 result SHALL be held stable from DONE until the next LOAD.
REQ-027 start asserted while busy SHALL be ignored (no queueing).
REQ-028 Total cs_n-low time: (128+K+WAIT_BITS+128)*2*CLK_DIV clk cycles, K = key bits.

Reset
REQ-029 reset=1 SHALL force IDLE, cs_n=1, sclk=0, mosi=0, mode=0, busy=0, done=0, match=0, err=0, result=0, all counters 0, regardless of state.
REQ-030 Reset mid-transaction SHALL abort with no done pulse; the slave sees cs_n rise immediately.

Configuration
REQ-031 Macro AES_SPI_SEQ_COMPARE_EN defined: in DONE, match = (result == expected), held until next LOAD, which clears it.
REQ-032 Macro undefined: expected input unused, no compare logic, match tied 0.

Verification
REQ-033 size=00, msg=3243f6a8885a308d313198a2e0370734, key[255:128]=2b7e151628aed2a6abf7158809cf4f3c, slave model returns 3925841d02dc09fbdc118597196a0b32 -> result equals it, match=1 (macro on), cs_n low 400*2*CLK_DIV cycles.
REQ-034 size=01, key[255:64]=000102030405060708090a0b0c0d0e0f1011121314151617 -> 192 key bits observed on mosi, first key bit = key[64], cs_n low 464 bit periods.
REQ-035 size=11 with start -> err single-cycle pulse, cs_n stays 1, busy stays 0.
REQ-036 reset asserted during SEND_KEY bit 50 -> all outputs at reset values same cycle, no done; next start runs a full clean transaction.
REQ-037 start held high for whole transaction -> exactly one done pulse, then a second transaction begins from IDLE.
REQ-038 expected != slave result, macro on -> match=0; macro off -> match=0 for any data.

Source files
------------

// File: rtl/aes_spi_if.sv
// Bundles the request/status/SPI signals of the AES SPI sequencer.
// master drives requests and miso; slave is the sequencer itself.
interface aes_spi_if;
  logic         start;
  logic [1:0]   size;
  logic [127:0] msg;
  logic [255:0] key;
  logic [127:0] expected;
  logic         miso;
  logic         cs_n;
  logic         sclk;
  logic         mosi;
  logic         mode;
  logic         busy;
  logic         done;
  logic         match;
  logic         err;
  logic [127:0] result;

  modport master (
    output start, size, msg, key, expected, miso,
    input  cs_n, sclk, mosi, mode, busy, done, match, err, result
  );

  modport slave (
    input  start, size, msg, key, expected, miso,
    output cs_n, sclk, mosi, mode, busy, done, match, err, result
  );
endinterface

// File: rtl/aes_spi_sequencer.sv
// Drives one AES load/readback transaction over SPI: message, key, idle gap, result.
// Define AES_SPI_SEQ_COMPARE_EN to compare the received result against 'expected'.
module aes_spi_sequencer #(
  parameter int unsigned CLK_DIV   = 50,
  parameter int unsigned WAIT_BITS = 16
) (
  input logic     clk_i,
  input logic     rst_i,
  aes_spi_if.slave bus_io
);

  localparam logic [8:0] DivLast  = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0] DivHalf  = 9'(CLK_DIV);
  localparam logic [8:0] WaitLast = 9'(WAIT_BITS - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StSendMsg, StSendKey, StWait, StRecv, StDone
  } state_e;

  state_e       state_q, state_d;
  logic [8:0]   div_q, div_d;
  logic [8:0]   bit_q, bit_d;
  logic [127:0] msg_q, msg_d;
  logic [255:0] key_q, key_d;
  logic [1:0]   size_q, size_d;
  logic [127:0] result_q, result_d;
  logic         err_q, err_d;
  logic         match_q, match_d;
  logic [8:0]   bit_last;
  logic         bit_end, sclk_rise;

  assign bit_end   = (div_q == DivLast);
  assign sclk_rise = (div_q == DivHalf);

  always_comb begin
    bit_last = 9'd127;
    case (state_q)
      StSendKey: begin
        case (size_q)
          2'b00:   bit_last = 9'd127;
          2'b01:   bit_last = 9'd191;
          default: bit_last = 9'd255;
        endcase
      end
      StWait:  bit_last = WaitLast;
      default: bit_last = 9'd127;
    endcase
  end

`ifdef AES_SPI_SEQ_COMPARE_EN
  logic [127:0] expected_q, expected_d;
`endif

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    msg_d    = msg_q;
    key_d    = key_q;
    size_d   = size_q;
    result_d = result_q;
    err_d    = 1'b0;
    match_d  = match_q;
`ifdef AES_SPI_SEQ_COMPARE_EN
    expected_d = expected_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          if (bus_io.size == 2'b11) begin
            err_d = 1'b1;
          end else begin
            state_d = StLoad;
            msg_d   = bus_io.msg;
            size_d  = bus_io.size;
`ifdef AES_SPI_SEQ_COMPARE_EN
            expected_d = bus_io.expected;
`endif
            // Pre-align the key so its first transmitted bit sits at key_q[0].
            case (bus_io.size)
              2'b00:   key_d = {128'b0, bus_io.key[255:128]};
              2'b01:   key_d = {64'b0, bus_io.key[255:64]};
              default: key_d = bus_io.key;
            endcase
          end
        end
      end
      // LOAD is the first clk cycle of message bit 0.
      StLoad: begin
        state_d = StSendMsg;
        div_d   = div_q + 9'd1;
        bit_d   = '0;
        match_d = 1'b0;
      end
      StDone: begin
        state_d = StIdle;
        div_d   = '0;
        bit_d   = '0;
      end
      default: begin
        div_d = bit_end ? 9'd0 : div_q + 9'd1;
        if (state_q == StRecv && sclk_rise) result_d = {bus_io.miso, result_q[127:1]};
        if (bit_end) begin
          if (state_q == StSendMsg) msg_d = msg_q >> 1;
          if (state_q == StSendKey) key_d = key_q >> 1;
          if (bit_q == bit_last) begin
            bit_d = '0;
            case (state_q)
              StSendMsg: state_d = StSendKey;
              StSendKey: state_d = StWait;
              StWait:    state_d = StRecv;
              default: begin
                state_d = StDone;
`ifdef AES_SPI_SEQ_COMPARE_EN
                match_d = (result_d == expected_q);
`endif
              end
            endcase
          end else begin
            bit_d = bit_q + 9'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      div_q    <= '0;
      bit_q    <= '0;
      msg_q    <= '0;
      key_q    <= '0;
      size_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      msg_q    <= msg_d;
      key_q    <= key_d;
      size_q   <= size_d;
      result_q <= result_d;
      err_q    <= err_d;
      match_q  <= match_d;
    end
  end

`ifdef AES_SPI_SEQ_COMPARE_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) expected_q <= '0;
    else       expected_q <= expected_d;
  end
  assign bus_io.match = match_q;
`else
  assign bus_io.match = 1'b0;
`endif

  assign bus_io.cs_n   = (state_q == StIdle) || (state_q == StDone);
  assign bus_io.sclk   = !bus_io.cs_n && (div_q >= DivHalf);
  assign bus_io.mosi   = ((state_q == StLoad) || (state_q == StSendMsg)) ? msg_q[0] :
                         (state_q == StSendKey) ? key_q[0] : 1'b0;
  assign bus_io.mode   = (state_q == StWait) || (state_q == StRecv);
  assign bus_io.busy   = (state_q != StIdle);
  assign bus_io.done   = (state_q == StDone);
  assign bus_io.err    = err_q;
  assign bus_io.result = result_q;

endmodule
